z3_bus_master_arbiter: RTL and testbench

- Sequences Zorro III bus mastership for the on-card SCSI DMA engine.
- Requests the bus from the backplane arbiter and waits for grant plus an idle bus. It then hands ownership to the DMA engine and releases the bus cleanly.
- Enforces a grant timeout and a minimum idle gap between tenures. Sits between the SCSI core's BR/BG/BGACK pins and the Zorro III arbitration and ownership signals.
- Inhibited until the card's autoconfig has completed.

---
 rtl/z3_bus_master_arbiter.sv | 144 ++++++++++++++
 tb/tb_z3_bus_master_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/z3_bus_master_arbiter.sv
// Zorro III bus-mastership sequencer for the on-card SCSI DMA engine.
// Optional tenure limit: define Z3_TENURE_LIMIT_EN to cap each tenure at TENURE_MAX cycles.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE    0  | no request outstanding; waits for dma_req while configured
// REQ     1  | Z_BR_n asserted, waiting for synchronised grant or timeout
// WAIT_IDLE 2| granted, waiting for the bus to go idle (FCS high)
// OWN     3  | card owns the bus, SCSI core granted
// DRAIN   4  | grant withdrawn, ownership held until the last cycle ends
// BACKOFF 5  | enforced idle gap before the next request
module z3_bus_master_arbiter #(
  parameter logic [7:0] GRANT_TIMEOUT = 8'd255,
  parameter logic [7:0] TENURE_MAX    = 8'd64,
  parameter logic [3:0] BACKOFF       = 4'd4
) (
  input  logic       clk,
  input  logic       IORST_n,
  input  logic       configured,
  input  logic       dma_req,
  input  logic       dma_busy,
  output logic       dma_grant,
  output logic       Z_BR_n,
  input  logic       Z_BG_n,
  input  logic       Z_FCS_n,
  output logic       Z_OWN_n,
  input  logic       Z_BCLR_n,
  output logic       timeout,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_IDLE = 3'd2,
    S_OWN       = 3'd3,
    S_DRAIN     = 3'd4,
    S_BACKOFF   = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] bg_sync_q, fcs_sync_q, bclr_sync_q;
  logic       br_n_q, br_n_d;
  logic       own_n_q, own_n_d;
  logic       grant_q, grant_d;
  logic       timeout_q, timeout_d;

  logic bg_low, fcs_high, bclr_low;
  logic grant_expired, backoff_done, tenure_hit;

  // Synchronisers reset to the bus-inactive levels.
  always_ff @(posedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      bg_sync_q   <= 2'b11;
      fcs_sync_q  <= 2'b11;
      bclr_sync_q <= 2'b11;
    end else begin
      bg_sync_q   <= {bg_sync_q[0], Z_BG_n};
      fcs_sync_q  <= {fcs_sync_q[0], Z_FCS_n};
      bclr_sync_q <= {bclr_sync_q[0], Z_BCLR_n};
    end
  end

  assign bg_low   = ~bg_sync_q[1];
  assign fcs_high = fcs_sync_q[1];
  assign bclr_low = ~bclr_sync_q[1];

  assign grant_expired = (cnt_q >= GRANT_TIMEOUT);
  assign backoff_done  = (({1'b0, cnt_q} + 9'd1) >= {5'd0, BACKOFF});

`ifdef Z3_TENURE_LIMIT_EN
  assign tenure_hit = (({1'b0, cnt_q} + 9'd1) >= {1'b0, TENURE_MAX});
`else
  logic unused_tenure_max;
  assign unused_tenure_max = ^TENURE_MAX;
  assign tenure_hit        = 1'b0;
`endif

  always_ff @(posedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      br_n_q    <= 1'b1;
      own_n_q   <= 1'b1;
      grant_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      br_n_q    <= br_n_d;
      own_n_q   <= own_n_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (dma_req && configured) state_d = S_REQ;
      end
      S_REQ: begin
        // Grant is checked before expiry so a coincident grant wins.
        if (!configured || !dma_req) state_d = S_IDLE;
        else if (bg_low)             state_d = S_WAIT_IDLE;
        else if (grant_expired)      state_d = S_BACKOFF;
      end
      S_WAIT_IDLE: begin
        if (fcs_high) state_d = S_OWN;
      end
      S_OWN: begin
        if ((!dma_req && !dma_busy) || bclr_low || tenure_hit) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!dma_busy && fcs_high) state_d = S_BACKOFF;
      end
      S_BACKOFF: begin
        if (backoff_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = 8'd0;
    else if (cnt_q == 8'hFF) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + 8'd1;
  end

  // Outputs are registered from the next state so they change on the transition edge.
  always_comb begin
    br_n_d    = ~((state_d == S_REQ) || (state_d == S_WAIT_IDLE));
    own_n_d   = ~((state_d == S_OWN) || (state_d == S_DRAIN));
    grant_d   = (state_d == S_OWN);
    timeout_d = (state_q == S_REQ) && (state_d == S_BACKOFF);
  end

  assign dma_grant = grant_q;
  assign Z_BR_n    = br_n_q;
  assign Z_OWN_n   = own_n_q;
  assign timeout   = timeout_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_z3_bus_master_arbiter.sv
// Directed self-checking bench for z3_bus_master_arbiter; honours Z3_TENURE_LIMIT_EN.
module tb_z3_bus_master_arbiter;

  logic       clk = 1'b0;
  logic       IORST_n, configured, dma_req, dma_busy;
  logic       Z_BG_n, Z_FCS_n, Z_BCLR_n;
  logic       dma_grant, Z_BR_n, Z_OWN_n, timeout;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       br_n;
    logic       own_n;
    logic       gnt;
    logic       to;
  } exp_t;

  exp_t sb[$];

  z3_bus_master_arbiter dut (
    .clk        (clk),
    .IORST_n    (IORST_n),
    .configured (configured),
    .dma_req    (dma_req),
    .dma_busy   (dma_busy),
    .dma_grant  (dma_grant),
    .Z_BR_n     (Z_BR_n),
    .Z_BG_n     (Z_BG_n),
    .Z_FCS_n    (Z_FCS_n),
    .Z_OWN_n    (Z_OWN_n),
    .Z_BCLR_n   (Z_BCLR_n),
    .timeout    (timeout),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected pin levels follow from the state the block should be in.
  task automatic push(input string tag, input logic [2:0] st, input logic to = 1'b0);
    exp_t e;
    e.tag   = tag;
    e.st    = st;
    e.br_n  = !(st == 3'd1 || st == 3'd2);
    e.own_n = !(st == 3'd3 || st == 3'd4);
    e.gnt   = (st == 3'd3);
    e.to    = to;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s.%s: observed %0d expected %0d", tag, fld, got, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "state", state_dbg, e.st);
      cmp(e.tag, "br_n", {2'b0, Z_BR_n}, {2'b0, e.br_n});
      cmp(e.tag, "own_n", {2'b0, Z_OWN_n}, {2'b0, e.own_n});
      cmp(e.tag, "grant", {2'b0, dma_grant}, {2'b0, e.gnt});
      cmp(e.tag, "timeout", {2'b0, timeout}, {2'b0, e.to});
    end
  endtask

  task automatic cnt_check(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic go_own(input string tag);
    int n;
    n = 0;
    configured = 1'b1;
    dma_req    = 1'b1;
    Z_BG_n     = 1'b0;
    Z_FCS_n    = 1'b1;
    Z_BCLR_n   = 1'b1;
    while (state_dbg !== 3'd3 && n < 40) begin
      cyc(1);
      n++;
    end
    cnt_check({tag, "_reach_own"}, int'(state_dbg), 3);
    Z_BG_n = 1'b1;
  endtask

  initial begin
    int bad;
    IORST_n = 1'b0; configured = 1'b0; dma_req = 1'b0; dma_busy = 1'b0;
    Z_BG_n = 1'b1; Z_FCS_n = 1'b1; Z_BCLR_n = 1'b1;

    push("reset", 3'd0);
    cyc(3); pop_check();
    IORST_n = 1'b1;
    cyc(2);

    // Unconfigured request is ignored.
    dma_req = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (Z_BR_n !== 1'b1 || state_dbg !== 3'd0) bad++;
    end
    cnt_check("unconfigured_ignored", bad, 0);

    // Normal tenure.
    configured = 1'b1;
    push("req_entry", 3'd1); cyc(1); pop_check();
    Z_BG_n = 1'b0;
    push("wait_idle", 3'd2); cyc(3); pop_check();
    push("own_entry", 3'd3); cyc(1); pop_check();
    Z_BG_n = 1'b1; dma_busy = 1'b1;
    push("own_hold", 3'd3); cyc(10); pop_check();
    dma_req = 1'b0; dma_busy = 1'b0;
    push("drain", 3'd4); cyc(1); pop_check();
    push("backoff", 3'd5); cyc(1); pop_check();
    push("backoff_last", 3'd5); cyc(3); pop_check();
    push("idle_after", 3'd0); cyc(1); pop_check();

    // BCLR while the SCSI core is mid-cycle.
    go_own("bclr");
    dma_busy = 1'b1; Z_BCLR_n = 1'b0; Z_FCS_n = 1'b0;
    push("bclr_drain", 3'd4); cyc(3); pop_check();
    Z_BCLR_n = 1'b1;
    push("drain_busy", 3'd4); cyc(5); pop_check();
    dma_busy = 1'b0;
    push("drain_fcs_low", 3'd4); cyc(4); pop_check();
    Z_FCS_n = 1'b1;
    push("drain_sync", 3'd4); cyc(2); pop_check();
    push("drain_release", 3'd5); cyc(1); pop_check();
    push("rereq_idle", 3'd0); cyc(4); pop_check();
    push("rereq", 3'd1); cyc(1); pop_check();

    // Grant timeout: exactly one pulse on the 256th cycle after REQ entry.
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      cyc(1);
      if (timeout !== 1'b0) bad++;
    end
    cnt_check("no_early_timeout", bad, 0);
    push("still_req", 3'd1); pop_check();
    push("timeout_pulse", 3'd5, 1'b1); cyc(1); pop_check();
    push("timeout_single", 3'd5); cyc(1); pop_check();
    push("req_after_to", 3'd1); cyc(4); pop_check();

    // configured falling while requesting: silent abandon.
    configured = 1'b0;
    push("unconfig_abandon", 3'd0); cyc(1); pop_check();
    configured = 1'b1;
    push("req_again", 3'd1); cyc(1); pop_check();

    // Grant arriving in the expiry cycle wins over timeout.
    cyc(253);
    Z_BG_n = 1'b0;
    push("bg_beats_timeout", 3'd2); cyc(3); pop_check();
    push("own_after_race", 3'd3); cyc(1); pop_check();
    Z_BG_n = 1'b1;

    // BCLR and dma_req drop in the same cycle.
    Z_BCLR_n = 1'b0;
    push("own_pre_race", 3'd3); cyc(2); pop_check();
    dma_req = 1'b0;
    push("race_drain", 3'd4); cyc(1); pop_check();
    Z_BCLR_n = 1'b1;
    push("race_backoff", 3'd5); cyc(1); pop_check();
    push("race_idle", 3'd0); cyc(4); pop_check();

    // Tenure limit.
    go_own("tenure");
`ifdef Z3_TENURE_LIMIT_EN
    push("tenure_hold", 3'd3); cyc(63); pop_check();
    push("tenure_forced", 3'd4); cyc(1); pop_check();
    push("tenure_backoff", 3'd5); cyc(1); pop_check();
    push("tenure_idle", 3'd0); cyc(4); pop_check();
    push("tenure_rereq", 3'd1); cyc(1); pop_check();
    go_own("reset_mid");
`else
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1);
      if (state_dbg !== 3'd3) bad++;
    end
    cnt_check("no_tenure_limit", bad, 0);
`endif

    // Asynchronous reset in the middle of a tenure.
    dma_busy = 1'b1;
    #2;
    IORST_n = 1'b0;
    #1;
    push("async_reset", 3'd0); pop_check();
    @(posedge clk); #1;
    IORST_n = 1'b1; dma_busy = 1'b0; dma_req = 1'b0;
    push("post_reset", 3'd0); cyc(2); pop_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
